player2_ctrl: RTL and testbench



---
 rtl/player2_if.sv | 25 ++
 rtl/player2_ctrl.sv | 179 +++++++++++++++++
 tb/tb_player2_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/player2_if.sv
// Player-2 controller bus: per-frame tick, buttons and kill in; sprite position/state out.
// The master drives the inputs (board or bench); the controller sits on the slave side.
interface player2_if;
  logic              frame_tick;
  logic              btn_up;
  logic              btn_down;
  logic              btn_left;
  logic              btn_right;
  logic              kill;
  logic signed [10:0] centerX2;
  logic signed [10:0] centerY2;
  logic [2:0]        sprite_num;
  logic              alive;
  logic              moving;

  modport master (
    output frame_tick, btn_up, btn_down, btn_left, btn_right, kill,
    input  centerX2, centerY2, sprite_num, alive, moving
  );

  modport slave (
    input  frame_tick, btn_up, btn_down, btn_left, btn_right, kill,
    output centerX2, centerY2, sprite_num, alive, moving
  );
endinterface

// File: rtl/player2_ctrl.sv
// Grid-locked movement and walk animation for player 2, advanced once per video frame.
// state   | meaning
// IDLE    | on a tile boundary, waiting for a button on frame_tick
// MOVE    | stepping toward the next tile boundary in r_dir, buttons ignored
// DEAD    | frozen after kill, left only by reset
module player2_ctrl #(
  parameter int START_X  = 64,
  parameter int START_Y  = 64,
  parameter int X_MIN    = 32,
  parameter int X_MAX    = 736,
  parameter int Y_MIN    = 32,
  parameter int Y_MAX    = 536,
  parameter int TILE     = 32,
  parameter int STEP     = 2,
  parameter int ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  player2_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_MOVE, ST_DEAD} state_t;
  typedef enum logic [1:0] {DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam int TILE_BITS = $clog2(TILE);
  localparam int CNT_W     = $clog2(ANIM_DIV + 1);

  localparam logic signed [11:0] C_TILE  = 12'(TILE);
  localparam logic signed [11:0] C_X_MIN = 12'(X_MIN);
  localparam logic signed [11:0] C_X_MAX = 12'(X_MAX);
  localparam logic signed [11:0] C_Y_MIN = 12'(Y_MIN);
  localparam logic signed [11:0] C_Y_MAX = 12'(Y_MAX);
  localparam logic signed [10:0] C_STEP  = 11'(STEP);
  localparam logic signed [10:0] C_START_X = 11'(START_X);
  localparam logic signed [10:0] C_START_Y = 11'(START_Y);

  state_t             r_state, w_state_nxt;
  dir_t               r_dir, w_dir_nxt;
  logic signed [10:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_phase, w_phase_nxt;

  logic               w_any_btn;
  dir_t               w_sel_dir;
  dir_t               w_step_dir;
  logic signed [11:0] w_tgt_x, w_tgt_y;
  logic               w_tgt_ok;
  logic signed [10:0] w_step_x, w_step_y;
  logic               w_aligned;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [2:0]         w_sprite;

  assign w_any_btn = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_sel_dir = DIR_RIGHT;
    if (bus.btn_up)        w_sel_dir = DIR_UP;
    else if (bus.btn_down) w_sel_dir = DIR_DOWN;
    else if (bus.btn_left) w_sel_dir = DIR_LEFT;
  end

  // One-tile target is computed one bit wider so the bounds check cannot wrap.
  always_comb begin
    w_tgt_x = 12'(r_x);
    w_tgt_y = 12'(r_y);
    case (w_sel_dir)
      DIR_UP:    w_tgt_y = 12'(r_y) - C_TILE;
      DIR_DOWN:  w_tgt_y = 12'(r_y) + C_TILE;
      DIR_LEFT:  w_tgt_x = 12'(r_x) - C_TILE;
      default:   w_tgt_x = 12'(r_x) + C_TILE;
    endcase
  end

  assign w_tgt_ok = (w_tgt_x >= C_X_MIN) && (w_tgt_x <= C_X_MAX) &&
                    (w_tgt_y >= C_Y_MIN) && (w_tgt_y <= C_Y_MAX);

  assign w_step_dir = (r_state == ST_IDLE) ? w_sel_dir : r_dir;

  always_comb begin
    w_step_x = r_x;
    w_step_y = r_y;
    case (w_step_dir)
      DIR_UP:    w_step_y = r_y - C_STEP;
      DIR_DOWN:  w_step_y = r_y + C_STEP;
      DIR_LEFT:  w_step_x = r_x - C_STEP;
      default:   w_step_x = r_x + C_STEP;
    endcase
  end

  always_comb begin
    if (w_step_dir == DIR_UP || w_step_dir == DIR_DOWN)
      w_aligned = (w_step_y[TILE_BITS-1:0] == '0);
    else
      w_aligned = (w_step_x[TILE_BITS-1:0] == '0);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (bus.kill) begin
      w_state_nxt = ST_DEAD;
    end else if (bus.frame_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_btn) begin
            w_dir_nxt = w_sel_dir;
            if (w_tgt_ok) begin
              w_state_nxt = ST_MOVE;
              w_x_nxt     = w_step_x;
              w_y_nxt     = w_step_y;
              w_phase_nxt = 1'b1;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_MOVE: begin
          w_x_nxt = w_step_x;
          w_y_nxt = w_step_y;
          // Landing on a boundary wins over a same-tick phase toggle.
          if (w_aligned) begin
            w_state_nxt = ST_IDLE;
            w_phase_nxt = 1'b0;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == CNT_W'(ANIM_DIV)) begin
            w_phase_nxt = ~r_phase;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_DOWN;
      r_x     <= C_START_X;
      r_y     <= C_START_Y;
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_sprite = 3'd0;
    if (r_state == ST_DEAD) begin
      w_sprite = 3'd6;
    end else begin
      case (r_dir)
        DIR_DOWN:  w_sprite = 3'd0 + {2'b00, r_phase};
        DIR_UP:    w_sprite = 3'd2 + {2'b00, r_phase};
        DIR_LEFT:  w_sprite = 3'd4;
        default:   w_sprite = 3'd5;
      endcase
    end
  end

  assign bus.centerX2   = r_x;
  assign bus.centerY2   = r_y;
  assign bus.sprite_num = w_sprite;
  assign bus.alive      = (r_state != ST_DEAD);
  assign bus.moving     = (r_state == ST_MOVE);

endmodule

// File: tb/tb_player2_ctrl.sv
// Directed vector table plus a sparse-tick walk for the player-2 movement controller.
module tb_player2_ctrl;

  logic clk;
  logic reset_n;
  player2_if bus ();

  player2_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // btn = {up, down, left, right, kill}
  typedef struct {
    int         n;
    logic       rst_n;
    logic       tick;
    logic [4:0] btn;
    int         ex;
    int         ey;
    int         es;
    logic       ea;
    logic       em;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  task automatic add(input int n, input logic rst_n, input logic tick, input logic [4:0] btn,
                     input int ex, input int ey, input int es, input logic ea, input logic em);
    vec_t v;
    v.n = n; v.rst_n = rst_n; v.tick = tick; v.btn = btn;
    v.ex = ex; v.ey = ey; v.es = es; v.ea = ea; v.em = em;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic tick, input logic [4:0] btn);
    reset_n        = rst_n;
    bus.frame_tick = tick;
    bus.btn_up     = btn[4];
    bus.btn_down   = btn[3];
    bus.btn_left   = btn[2];
    bus.btn_right  = btn[1];
    bus.kill       = btn[0];
  endtask

  task automatic check_all(input string tag, input int ex, input int ey, input int es,
                           input logic ea, input logic em);
    chk({tag, " X"},      int'(bus.centerX2), ex);
    chk({tag, " Y"},      int'(bus.centerY2), ey);
    chk({tag, " sprite"}, int'(bus.sprite_num), es);
    chk({tag, " alive"},  int'(bus.alive), int'(ea));
    chk({tag, " moving"}, int'(bus.moving), int'(em));
  endtask

  initial begin
    int ticks;
    int cyc;
    int prev_x;
    checks = 0;
    errors = 0;
    drive(1'b0, 1'b0, 5'b00000);

    // reset with buttons and ticks
    add(2, 0, 0, 5'b10010,  64,  64, 0, 1, 0);
    add(3, 0, 1, 5'b11110,  64,  64, 0, 1, 0);
    add(3, 1, 0, 5'b00010,  64,  64, 0, 1, 0);
    // right step
    add(1, 1, 1, 5'b00010,  66,  64, 5, 1, 1);
    add(14,1, 1, 5'b00000,  94,  64, 5, 1, 1);
    add(1, 1, 1, 5'b00000,  96,  64, 5, 1, 0);
    add(1, 1, 1, 5'b00000,  96,  64, 5, 1, 0);
    add(4, 1, 0, 5'b00010,  96,  64, 5, 1, 0);
    // up to the top bound, then blocked, then down
    add(1, 0, 0, 5'b00000,  64,  64, 0, 1, 0);
    add(1, 1, 1, 5'b10000,  64,  62, 3, 1, 1);
    add(7, 1, 1, 5'b00000,  64,  48, 2, 1, 1);
    add(8, 1, 1, 5'b00000,  64,  32, 2, 1, 0);
    add(3, 1, 1, 5'b10000,  64,  32, 2, 1, 0);
    add(1, 1, 1, 5'b01000,  64,  34, 1, 1, 1);
    add(15,1, 1, 5'b00000,  64,  64, 0, 1, 0);
    // animation with down held
    add(1, 1, 1, 5'b01000,  64,  66, 1, 1, 1);
    add(6, 1, 1, 5'b01000,  64,  78, 1, 1, 1);
    add(1, 1, 1, 5'b01000,  64,  80, 0, 1, 1);
    add(7, 1, 1, 5'b01000,  64,  94, 0, 1, 1);
    add(1, 1, 1, 5'b01000,  64,  96, 0, 1, 0);
    add(1, 1, 1, 5'b01000,  64,  98, 1, 1, 1);
    // priority and mid-step button changes
    add(1, 0, 0, 5'b00000,  64,  64, 0, 1, 0);
    add(1, 1, 1, 5'b10010,  64,  62, 3, 1, 1);
    add(7, 1, 1, 5'b00100,  64,  48, 2, 1, 1);
    add(8, 1, 1, 5'b00100,  64,  32, 2, 1, 0);
    add(1, 1, 1, 5'b00100,  62,  32, 4, 1, 1);
    // kill mid-step with simultaneous tick
    add(1, 0, 0, 5'b00000,  64,  64, 0, 1, 0);
    add(8, 1, 1, 5'b01000,  64,  80, 0, 1, 1);
    add(1, 1, 1, 5'b01001,  64,  80, 6, 0, 0);
    add(5, 1, 1, 5'b11110,  64,  80, 6, 0, 0);
    add(1, 0, 1, 5'b00000,  64,  64, 0, 1, 0);
    // kill in idle without a tick
    add(1, 1, 0, 5'b00001,  64,  64, 6, 0, 0);
    add(1, 0, 0, 5'b00000,  64,  64, 0, 1, 0);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].n; r++) begin
        @(negedge clk);
        drive(vecs[i].rst_n, vecs[i].tick, vecs[i].btn);
        @(posedge clk);
      end
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].es,
                vecs[i].ea, vecs[i].em);
    end

    // Sparse ticks: one every third cycle, outputs must hold in between.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'b00010);
    @(posedge clk);
    #1;
    check_all("sparse first", 66, 64, 5, 1, 1);
    ticks = 1;
    cyc   = 0;
    while (bus.moving && cyc < 300) begin
      prev_x = int'(bus.centerX2);
      @(negedge clk);
      drive(1'b1, (cyc % 3) == 2, 5'b00000);
      @(posedge clk);
      #1;
      if (bus.frame_tick) ticks++;
      else chk("sparse hold X", int'(bus.centerX2), prev_x);
      cyc++;
    end
    chk("sparse done", int'(bus.moving), 0);
    chk("sparse ticks", ticks, 16);
    chk("sparse X", int'(bus.centerX2), 96);

    @(negedge clk);
    drive(1'b1, 1'b0, 5'b00000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
